// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: micro-sequencer and sole write master of an 8-entry register file.
//
// Accepts one instruction at a time over a valid/ready handshake. Each instruction is
// sequenced through IDLE -> READ -> WB1 (-> WB2 for SWAP) -> IDLE.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake; ready only in IDLE
//   instr_op/rd/rs1/rs2/imm    instruction fields, latched on acceptance
//   rf_read_reg1/2             register file read addresses (latched rs1/rs2)
//   rf_read_data1/2            asynchronous register file read data
//   rf_we/write_reg/write_data register file synchronous write port
//   done                       one-cycle pulse on instruction completion
//   result, flag_zero/carry    last completed instruction's primary result and flags
module regfile_op_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [2:0]       instr_rd,
  input  logic [2:0]       instr_rs1,
  input  logic [2:0]       instr_rs2,
  input  logic [WIDTH-1:0] instr_imm,
  output logic [2:0]       rf_read_reg1,
  output logic [2:0]       rf_read_reg2,
  input  logic [WIDTH-1:0] rf_read_data1,
  input  logic [WIDTH-1:0] rf_read_data2,
  output logic             rf_we,
  output logic [2:0]       rf_write_reg,
  output logic [WIDTH-1:0] rf_write_data,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry
);

  localparam logic [2:0] OpNop  = 3'd0;
  localparam logic [2:0] OpAdd  = 3'd1;
  localparam logic [2:0] OpSub  = 3'd2;
  localparam logic [2:0] OpAnd  = 3'd3;
  localparam logic [2:0] OpXor  = 3'd4;
  localparam logic [2:0] OpLdi  = 3'd5;
  localparam logic [2:0] OpMov  = 3'd6;
  localparam logic [2:0] OpSwap = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWb1,
    StWb2
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       op_q, op_d;
  logic [2:0]       rd_q, rd_d;
  logic [2:0]       rs1_q, rs1_d;
  logic [2:0]       rs2_q, rs2_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;

  // ALU on the latched operands
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  always_comb begin
    sum_ext   = {1'b0, op_a_q} + {1'b0, op_b_q};
    // Top bit of the extended difference is the unsigned borrow (op_a < op_b).
    diff_ext  = {1'b0, op_a_q} - {1'b0, op_b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OpSub: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
      end
      OpAnd:   alu_res = op_a_q & op_b_q;
      OpXor:   alu_res = op_a_q ^ op_b_q;
      OpLdi:   alu_res = imm_q;
      OpMov:   alu_res = op_a_q;
      OpSwap:  alu_res = op_b_q;
      default: alu_res = '0;
    endcase
  end

  // Write request before register-0 suppression
  logic             wr_req;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Architectural result/flag update
  logic             upd;
  logic [WIDTH-1:0] upd_val;
  logic             upd_carry;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    wr_req      = 1'b0;
    wr_addr     = 3'd0;
    wr_data     = '0;
    upd         = 1'b0;
    upd_val     = '0;
    upd_carry   = 1'b0;

    unique case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr_op;
          rd_d    = instr_rd;
          rs1_d   = instr_rs1;
          rs2_d   = instr_rs2;
          imm_d   = instr_imm;
          state_d = StRead;
        end
      end
      StRead: begin
        op_a_d  = rf_read_data1;
        op_b_d  = rf_read_data2;
        state_d = StWb1;
      end
      StWb1: begin
        if (op_q == OpNop) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (op_q == OpSwap) begin
          wr_req  = 1'b1;
          wr_addr = rs1_q;
          wr_data = op_b_q;
          state_d = StWb2;
        end else begin
          wr_req    = 1'b1;
          wr_addr   = rd_q;
          wr_data   = alu_res;
          done      = 1'b1;
          upd       = 1'b1;
          upd_val   = alu_res;
          upd_carry = alu_carry;
          state_d   = StIdle;
        end
      end
      StWb2: begin
        wr_req    = 1'b1;
        wr_addr   = rs2_q;
        wr_data   = op_a_q;
        done      = 1'b1;
        upd       = 1'b1;
        upd_val   = op_b_q;
        upd_carry = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    result_d = upd ? upd_val : result_q;
    zero_d   = upd ? (upd_val == '0) : zero_q;
    carry_d  = upd ? upd_carry : carry_q;
  end

  // Register 0 is hard-zero: suppress the strobe, and idle the bus whenever no write is issued.
  always_comb begin
    rf_we         = wr_req && (wr_addr != 3'd0);
    rf_write_reg  = rf_we ? wr_addr : 3'd0;
    rf_write_data = rf_we ? wr_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      rd_q     <= 3'd0;
      rs1_q    <= 3'd0;
      rs2_q    <= 3'd0;
      imm_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  assign rf_read_reg1 = rs1_q;
  assign rf_read_reg2 = rs2_q;
  assign result       = result_q;
  assign flag_zero    = zero_q;
  assign flag_carry   = carry_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed plus randomized bench for regfile_op_sequencer with a behavioural register file
// and an arithmetic reference model of each instruction.
module tb_regfile_op_sequencer;

  localparam int W = 4;
  localparam int M = 1 << W;

  localparam int NOP = 0, ADD = 1, SUB = 2, AND = 3, XOR = 4, LDI = 5, MOV = 6, SWAP = 7;

  logic         clk;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   instr_op;
  logic [2:0]   instr_rd;
  logic [2:0]   instr_rs1;
  logic [2:0]   instr_rs2;
  logic [W-1:0] instr_imm;
  logic [2:0]   rf_read_reg1;
  logic [2:0]   rf_read_reg2;
  logic [W-1:0] rf_read_data1;
  logic [W-1:0] rf_read_data2;
  logic         rf_we;
  logic [2:0]   rf_write_reg;
  logic [W-1:0] rf_write_data;
  logic         done;
  logic [W-1:0] result;
  logic         flag_zero;
  logic         flag_carry;

  regfile_op_sequencer #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_rd      (instr_rd),
    .instr_rs1     (instr_rs1),
    .instr_rs2     (instr_rs2),
    .instr_imm     (instr_imm),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_reg2  (rf_read_reg2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .rf_we         (rf_we),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .done          (done),
    .result        (result),
    .flag_zero     (flag_zero),
    .flag_carry    (flag_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: async reads, sync write. Accepts writes to r0 so a
  // sequencer that fails to suppress them is visible.
  logic [W-1:0] rf [8];
  always @(posedge clk) if (rf_we) rf[rf_write_reg] <= rf_write_data;
  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  // Reference model state
  int model_rf [8];
  int exp_result, exp_zero, exp_carry;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input int op, input int a, input int b, input int imm,
                                 output int res, output int cy);
    res = 0;
    cy  = 0;
    case (op)
      ADD: begin res = (a + b) % M; cy = (a + b >= M) ? 1 : 0; end
      SUB: begin res = (a - b + M) % M; cy = (a < b) ? 1 : 0; end
      AND: res = a & b;
      XOR: res = a ^ b;
      LDI: res = imm;
      MOV: res = a;
      SWAP: res = b;
      default: res = 0;
    endcase
  endfunction

  task automatic junk(input bit hold);
    instr_valid = hold;
    instr_op    = 3'($urandom);
    instr_rd    = 3'($urandom);
    instr_rs1   = 3'($urandom);
    instr_rs2   = 3'($urandom);
    instr_imm   = W'($urandom);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm,
                       input bit hold);
    int a, b, res, cy, waddr, wdata;
    bit has_wr;
    instr_valid = 1'b1;
    instr_op    = 3'(op);
    instr_rd    = 3'(rd);
    instr_rs1   = 3'(rs1);
    instr_rs2   = 3'(rs2);
    instr_imm   = W'(imm);
    a = model_rf[rs1];
    b = model_rf[rs2];
    ref_op(op, a, b, imm, res, cy);

    @(posedge clk);
    @(negedge clk);
    junk(hold);
    chk("read_ready", instr_ready, 0);
    chk("read_done", done, 0);
    chk("read_we", rf_we, 0);
    chk("read_addr1", rf_read_reg1, rs1);
    chk("read_addr2", rf_read_reg2, rs2);

    @(negedge clk);
    junk(hold);
    has_wr = (op != NOP);
    waddr  = (op == SWAP) ? rs1 : rd;
    wdata  = (op == SWAP) ? b : res;
    if (!has_wr || waddr == 0) begin has_wr = 0; waddr = 0; wdata = 0; end
    chk("wb1_ready", instr_ready, 0);
    chk("wb1_done", done, (op == SWAP) ? 0 : 1);
    chk("wb1_we", rf_we, has_wr);
    chk("wb1_wreg", rf_write_reg, waddr);
    chk("wb1_wdata", rf_write_data, wdata);
    if (has_wr) model_rf[waddr] = wdata;

    if (op == SWAP) begin
      @(negedge clk);
      junk(hold);
      chk("wb2_ready", instr_ready, 0);
      chk("wb2_done", done, 1);
      chk("wb2_we", rf_we, (rs2 != 0) ? 1 : 0);
      chk("wb2_wreg", rf_write_reg, rs2);
      chk("wb2_wdata", rf_write_data, (rs2 != 0) ? a : 0);
      if (rs2 != 0) model_rf[rs2] = a;
    end

    if (op != NOP) begin
      exp_result = res;
      exp_zero   = (res == 0) ? 1 : 0;
      exp_carry  = cy;
    end

    @(negedge clk);
    junk(1'b0);
    chk("idle_ready", instr_ready, 1);
    chk("idle_done", done, 0);
    chk("idle_we", rf_we, 0);
    chk("result", result, exp_result);
    chk("flag_zero", flag_zero, exp_zero);
    chk("flag_carry", flag_carry, exp_carry);
    for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), rf[i], model_rf[i]);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin rf[i] = '0; model_rf[i] = 0; end
    exp_result = 0; exp_zero = 0; exp_carry = 0;
    rst_n = 1'b0;
    junk(1'b0);
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", flag_zero, 0);
    chk("rst_carry", flag_carry, 0);
    chk("rst_raddr1", rf_read_reg1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort an LDI mid-READ with reset
    instr_valid = 1'b1; instr_op = 3'(LDI); instr_rd = 3'd3; instr_imm = W'(5);
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_read", instr_ready, 0);
    rst_n = 1'b0;
    junk(1'b0);
    #1;
    chk("abort_ready", instr_ready, 1);
    chk("abort_we", rf_we, 0);
    @(negedge clk);
    chk("abort_we2", rf_we, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_r3", rf[3], 0);
    chk("abort_result", result, 0);

    issue(LDI, 3, 0, 0, 'hA, 0);
    // ADD overflow
    issue(LDI, 1, 0, 0, 'h9, 0);
    issue(LDI, 2, 0, 0, 'h8, 0);
    issue(ADD, 4, 1, 2, 0, 0);
    // SUB zero then borrow
    issue(LDI, 2, 0, 0, 'h9, 0);
    issue(SUB, 5, 1, 2, 0, 0);
    issue(LDI, 2, 0, 0, 'h8, 0);
    issue(SUB, 5, 2, 1, 0, 0);
    // SWAP
    issue(LDI, 1, 0, 0, 'h3, 0);
    issue(LDI, 2, 0, 0, 'hC, 0);
    issue(SWAP, 0, 1, 2, 0, 0);
    // Register-0 suppression, then read r0 back
    issue(LDI, 1, 0, 0, 'h5, 0);
    issue(MOV, 0, 1, 0, 0, 0);
    issue(MOV, 6, 0, 0, 0, 0);
    issue(NOP, 2, 1, 1, 'h7, 0);
    issue(SWAP, 0, 3, 3, 0, 0);
    // Back-to-back with valid held high and garbage while busy
    issue(ADD, 6, 1, 2, 0, 1);
    issue(XOR, 7, 6, 1, 0, 1);
    issue(AND, 5, 7, 3, 0, 0);

    for (int n = 0; n < 60; n++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
